// File: rtl/jesd204b_pkg.sv
// Shared constants and state encoding for the JESD204B receive data-link layer.
package jesd204b_pkg;

  localparam logic [7:0] K_CHAR = 8'hBC;
  localparam logic [7:0] R_CHAR = 8'h1C;
  localparam logic [7:0] A_CHAR = 8'h7C;
  localparam logic [7:0] Q_CHAR = 8'h9C;
  localparam logic [7:0] F_CHAR = 8'hFC;

  // ILAS is always four multiframes long
  localparam int ILAS_MF = 4;

  typedef enum logic [1:0] {
    ST_CGS       = 2'd0,
    ST_WAIT_ILAS = 2'd1,
    ST_ILAS      = 2'd2,
    ST_DATA      = 2'd3
  } dl_state_t;

endpackage

// File: rtl/jesd204b_dl_rx_charrepl.sv
// DATA-phase frame/multiframe tracker: undoes /A/ and /F/ replacement and flags
// control characters that are out of place. At most one error per word.
module jesd204b_dl_rx_charrepl
  import jesd204b_pkg::*;
#(
  parameter int OCTET_PER_SENT = 4,
  parameter int OCTETS_PER_FR  = 4,
  parameter int FRAMES_PER_MF  = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        active,
  input  logic [OCTET_PER_SENT*8-1:0] data,
  input  logic [OCTET_PER_SENT-1:0]   ctrl,
  output logic [OCTET_PER_SENT*8-1:0] repl,
  output logic                        word_err
);

  localparam int NO  = OCTET_PER_SENT;
  localparam int WPF = OCTETS_PER_FR / NO;
  localparam int FW  = (WPF > 1) ? $clog2(WPF) : 1;
  localparam int RW  = (FRAMES_PER_MF > 1) ? $clog2(FRAMES_PER_MF) : 1;

  logic [NO-1:0][7:0] oct, oct_o;
  logic [NO-1:0]      oct_err;
  logic [FW-1:0]      fw_q;
  logic [RW-1:0]      fr_q;
  logic [7:0]         last_q;
  logic               fr_end, mf_end;

  assign oct    = data;
  assign fr_end = (fw_q == FW'(WPF-1));
  assign mf_end = fr_end && (fr_q == RW'(FRAMES_PER_MF-1));

  for (genvar j = 0; j < NO; j++) begin : g_oct
    localparam bit LAST = (j == NO-1);
    logic at_fe, at_me, swap;
    assign at_fe      = LAST && fr_end;
    assign at_me      = at_fe && mf_end;
    assign swap       = ctrl[j] && (((oct[j] == F_CHAR) && at_fe) || ((oct[j] == A_CHAR) && at_me));
    assign oct_o[j]   = swap ? last_q : oct[j];
    assign oct_err[j] = ctrl[j] && !swap;
  end

  assign repl     = oct_o;
  assign word_err = |oct_err;

  // Restarts at MF0 whenever the link is outside DATA
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fw_q   <= '0;
      fr_q   <= '0;
      last_q <= '0;
    end else if (!active) begin
      fw_q   <= '0;
      fr_q   <= '0;
      last_q <= '0;
    end else if (fr_end) begin
      fw_q   <= '0;
      fr_q   <= mf_end ? '0 : fr_q + 1'b1;
      last_q <= oct_o[NO-1];
    end else begin
      fw_q   <= fw_q + 1'b1;
    end
  end

endmodule

// File: rtl/jesd204b_dl_rx_sync.sv
// Per-lane JESD204B RX link establishment: CGS, ILAS check/config capture, then
// user data with character replacement undone.
module jesd204b_dl_rx_sync
  import jesd204b_pkg::*;
#(
  parameter int LANE_DATA_WIDTH = 32,
  parameter int OCTET_PER_SENT  = 4,
  parameter int OCTETS_PER_FR   = 4,
  parameter int FRAMES_PER_MF   = 8,
  parameter int K_THRESH        = 4,
  parameter int ERR_THRESH      = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       sync_request,
  input  logic [LANE_DATA_WIDTH-1:0] in,
  input  logic [OCTET_PER_SENT-1:0]  in_ctrl,
  output logic                       sync_n,
  output logic [LANE_DATA_WIDTH-1:0] out,
  output logic                       out_valid,
  output logic [14*8-1:0]            cfg_out,
  output logic                       cfg_valid,
  output logic                       ilas_err,
  output logic [7:0]                 err_cnt,
  output logic [1:0]                 state
);

  localparam int NO  = OCTET_PER_SENT;
  localparam int WPM = OCTETS_PER_FR * FRAMES_PER_MF / NO;
  localparam int WW  = (WPM > 1) ? $clog2(WPM) : 1;
  localparam int KW  = $clog2(K_THRESH + 1);

  dl_state_t              state_q, nxt;
  logic [NO-1:0][7:0]     oct;
  logic [NO-1:0]          oct_k, oct_ilas_err;
  logic [KW-1:0]          k_cnt;
  logic [WW-1:0]          w_q, cur_w;
  logic [1:0]             m_q, cur_m;
  logic [13:0][7:0]       cfg_q, cfg_d;
  logic [LANE_DATA_WIDTH-1:0] repl_word;
  logic is_k, k_full, err_full, r_start, ilas_bad, ilas_last;
  logic ilas_fail, resync, word_err, data_keep;

  assign oct = in;

  // The /R/ word that opens ILAS is checked as MF0 word 0 while still in WAIT_ILAS
  assign cur_w = (state_q == ST_ILAS) ? w_q : '0;
  assign cur_m = (state_q == ST_ILAS) ? m_q : '0;

  for (genvar j = 0; j < NO; j++) begin : g_oct
    localparam bit LAST = (j == NO-1);
    logic need_a, ctrl_ok;
    assign oct_k[j] = in_ctrl[j] && (oct[j] == K_CHAR);
    assign need_a   = LAST && (cur_w == WW'(WPM-1));
    assign ctrl_ok  = ((j == 0) && (cur_m == 2'd0) && (cur_w == '0) && (oct[j] == R_CHAR)) ||
                      ((j == 1) && (cur_m == 2'd1) && (cur_w == '0) && (oct[j] == Q_CHAR));
    assign oct_ilas_err[j] = need_a ? !(in_ctrl[j] && (oct[j] == A_CHAR))
                                    : (in_ctrl[j] && !ctrl_ok);
  end

  // MF1 octets 2..15 land in cfg octets 0..13
  for (genvar n = 0; n < 14; n++) begin : g_cfg
    localparam int IDX = n + 2;
    assign cfg_d[n] = ((state_q == ST_ILAS) && (m_q == 2'd1) && (w_q == WW'(IDX / NO)))
                      ? oct[IDX % NO] : cfg_q[n];
  end

  assign is_k      = &oct_k;
  assign k_full    = is_k && (k_cnt == KW'(K_THRESH-1));
  assign err_full  = (err_cnt >= 8'(ERR_THRESH));
  assign r_start   = in_ctrl[0] && (oct[0] == R_CHAR);
  assign ilas_bad  = |oct_ilas_err;
  assign ilas_last = (w_q == WW'(WPM-1)) && (m_q == 2'(ILAS_MF-1));

  jesd204b_dl_rx_charrepl #(
    .OCTET_PER_SENT(OCTET_PER_SENT),
    .OCTETS_PER_FR (OCTETS_PER_FR),
    .FRAMES_PER_MF (FRAMES_PER_MF)
  ) u_charrepl (
    .clk     (clk),
    .reset   (reset),
    .active  (state_q == ST_DATA),
    .data    (in),
    .ctrl    (in_ctrl),
    .repl    (repl_word),
    .word_err(word_err)
  );

  always_comb begin
    nxt       = state_q;
    ilas_fail = 1'b0;
    resync    = 1'b0;
    case (state_q)
      ST_CGS:       if (k_full) nxt = ST_WAIT_ILAS;
      ST_WAIT_ILAS: begin
        if (!is_k) begin
          if (r_start && !ilas_bad) nxt = ST_ILAS;
          else begin
            nxt       = ST_CGS;
            ilas_fail = 1'b1;
          end
        end
      end
      ST_ILAS: begin
        if (ilas_bad) begin
          nxt       = ST_CGS;
          ilas_fail = 1'b1;
        end else if (ilas_last) nxt = ST_DATA;
      end
      ST_DATA: begin
        if (k_full || err_full) begin
          nxt    = ST_CGS;
          resync = 1'b1;
        end
      end
      default: nxt = ST_CGS;
    endcase
    if (sync_request) begin
      nxt       = ST_CGS;
      resync    = 1'b1;
      ilas_fail = 1'b0;
    end
  end

  assign data_keep = (state_q == ST_DATA) && (nxt == ST_DATA);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_CGS;
      sync_n    <= 1'b0;
      k_cnt     <= '0;
      w_q       <= '0;
      m_q       <= '0;
      cfg_q     <= '0;
      cfg_valid <= 1'b0;
      ilas_err  <= 1'b0;
      err_cnt   <= '0;
      out       <= '0;
      out_valid <= 1'b0;
    end else begin
      state_q   <= nxt;
      sync_n    <= (nxt != ST_CGS);
      cfg_q     <= cfg_d;
      cfg_valid <= (nxt == ST_DATA);
      out_valid <= data_keep;
      out       <= data_keep ? repl_word : '0;

      // K words only count toward lock/resync in CGS and DATA
      if (sync_request || (nxt != state_q)) k_cnt <= '0;
      else if ((state_q == ST_CGS) || (state_q == ST_DATA)) k_cnt <= is_k ? k_cnt + 1'b1 : '0;

      if (nxt == ST_ILAS) begin
        if (state_q != ST_ILAS) begin
          w_q <= WW'(1);
          m_q <= '0;
        end else if (w_q == WW'(WPM-1)) begin
          w_q <= '0;
          m_q <= m_q + 2'd1;
        end else begin
          w_q <= w_q + 1'b1;
        end
      end else begin
        w_q <= '0;
        m_q <= '0;
      end

      if (resync) ilas_err <= 1'b0;
      else if (ilas_fail) ilas_err <= 1'b1;

      err_cnt <= data_keep ? ((word_err && (err_cnt != 8'hFF)) ? err_cnt + 8'd1 : err_cnt) : 8'd0;
    end
  end

  assign cfg_out = cfg_q;
  assign state   = state_q;

endmodule
